multi_fetch_logic: RTL

MULTI_FETCH_LOGIC -- requirements
Module: multi_fetch_logic

---
 rtl/multi_fetch_logic_pkg.sv | 35 +++
 rtl/multi_fetch_logic_rr_arbiter.sv | 18 +
 rtl/multi_fetch_logic.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multi_fetch_logic_pkg.sv
// Shared definitions for the multi-channel tile fetcher: FSM encodings and
// the round-robin grant search used by the arbiter.
package multi_fetch_logic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCHING = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam int MAX_CH = 32;

    // Searches upward from last+1, wrapping at num_ch; returns last when nothing is requested.
    function automatic int rr_next_grant(input logic [MAX_CH-1:0] req,
                                         input int num_ch,
                                         input int last);
        int   idx;
        logic found;
        rr_next_grant = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            if (k <= num_ch && !found) begin
                idx = last + k;
                if (idx >= num_ch) begin
                    idx = idx - num_ch;
                end
                if (req[idx[4:0]]) begin
                    rr_next_grant = idx;
                    found = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/multi_fetch_logic_rr_arbiter.sv
// Round-robin arbiter: picks the next requesting channel after last_grant.
module rr_arbiter
    import multi_fetch_logic_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH-1:0]                              req,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] last_grant,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant,
    output logic                                           grant_valid
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    assign grant       = CH_W'(rr_next_grant(MAX_CH'(req), NUM_CH, int'(last_grant)));
    assign grant_valid = |req;

endmodule

// File: rtl/multi_fetch_logic.sv
// Shares one BRAM read port among NUM_CH tile buffers: round-robin grants,
// NUM_FETCHES_PER_TILE reads per tile, and a per-channel wrapping tile pointer.
module multi_fetch_logic
    import multi_fetch_logic_pkg::*;
#(
    parameter int NUM_CH               = 3,
    parameter int NUM_FETCHES_PER_TILE = 2,
    parameter int ADDR_WIDTH           = 11,
    parameter int PTR_WIDTH            = 9,
    parameter int RD_LATENCY           = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_CH-1:0]                              start_fetch,
    input  logic [NUM_CH-1:0]                              reset_ptr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                   cfg_base,
    input  logic [NUM_CH*PTR_WIDTH-1:0]                    cfg_tiles,
    input  logic                                           rd_stall,
    output logic [ADDR_WIDTH-1:0]                          bram_addr,
    output logic                                           bram_en,
    output logic                                           rd_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    output logic                                           rd_last,
    output logic [NUM_CH-1:0]                              fetch_done,
    output logic                                           busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W = (NUM_FETCHES_PER_TILE > 1) ? $clog2(NUM_FETCHES_PER_TILE) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NUM_FETCHES_PER_TILE - 1);

    state_t                 state;
    state_t                 state_next;
    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0]      grant_mask;
    logic [PTR_WIDTH-1:0]   ptr [NUM_CH];
    logic [OFF_W-1:0]       offset;
    logic [CH_W-1:0]        last_grant;
    logic [CH_W-1:0]        cur_ch;
    logic [CH_W-1:0]        grant;
    logic                   grant_valid;
    logic                   grant_fire;
    logic                   is_last;
    logic [ADDR_WIDTH-1:0]  base_arr  [NUM_CH];
    logic [PTR_WIDTH-1:0]   tiles_arr [NUM_CH];
    logic [ADDR_WIDTH-1:0]  cur_base;
    logic [PTR_WIDTH-1:0]   cur_ptr;
    logic [PTR_WIDTH-1:0]   cur_tiles;
    logic [PTR_WIDTH-1:0]   ptr_adv;
    logic [ADDR_WIDTH-1:0]  addr_calc;
    logic                   valid_pipe [RD_LATENCY];
    logic                   last_pipe  [RD_LATENCY];
    logic [CH_W-1:0]        ch_pipe    [RD_LATENCY];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cfg
        assign base_arr[c]  = cfg_base[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign tiles_arr[c] = cfg_tiles[c*PTR_WIDTH +: PTR_WIDTH];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .req         (pending),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign grant_fire = (state == IDLE) && grant_valid;
    assign is_last    = (offset == LAST_OFF);
    assign cur_base   = base_arr[cur_ch];
    assign cur_ptr    = ptr[cur_ch];
    assign cur_tiles  = tiles_arr[cur_ch];

    // A zero tile count leaves the pointer to wrap naturally at 2^PTR_WIDTH.
    assign ptr_adv   = ((cur_tiles != '0) && (cur_ptr == cur_tiles - 1'b1)) ? '0 : cur_ptr + 1'b1;
    assign addr_calc = cur_base
                     + ADDR_WIDTH'(cur_ptr) * ADDR_WIDTH'(NUM_FETCHES_PER_TILE)
                     + ADDR_WIDTH'(offset);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (grant_valid) state_next = FETCHING;
            FETCHING: if (!rd_stall && is_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_mask = '0;
        fetch_done = '0;
        if (grant_fire) begin
            grant_mask[grant] = 1'b1;
        end
        if (state == DONE) begin
            fetch_done[cur_ch] = 1'b1;
        end
    end

    assign bram_en   = (state == FETCHING) && !rd_stall;
    assign bram_addr = bram_en ? addr_calc : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            offset     <= '0;
            cur_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            state   <= state_next;
            // A re-request in the grant cycle survives the clear so the channel is served again.
            pending <= (pending & ~grant_mask) | start_fetch;
            if (grant_fire) begin
                cur_ch     <= grant;
                last_grant <= grant;
            end
            if (bram_en) begin
                offset <= offset + 1'b1;
            end else if (state == DONE) begin
                offset <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (reset_ptr[c]) begin
                    ptr[c] <= '0;
                end else if ((state == DONE) && (cur_ch == CH_W'(c))) begin
                    ptr[c] <= ptr_adv;
                end
            end
        end
    end

    // Read qualifiers travel alongside the BRAM's own latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                valid_pipe[i] <= 1'b0;
                last_pipe[i]  <= 1'b0;
                ch_pipe[i]    <= '0;
            end
        end else begin
            valid_pipe[0] <= bram_en;
            last_pipe[0]  <= bram_en && is_last;
            ch_pipe[0]    <= bram_en ? cur_ch : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
                ch_pipe[i]    <= ch_pipe[i-1];
            end
        end
    end

    assign rd_valid = valid_pipe[RD_LATENCY-1];
    assign rd_last  = last_pipe[RD_LATENCY-1];
    assign rd_ch    = ch_pipe[RD_LATENCY-1];

endmodule
